// File: rtl/sram_client_pkg.sv
// Shared types and defaults for the SRAM FIFO controller client port.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_client_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_REQ = 2'd1,
        RD_REQ = 2'd2,
        COOL   = 2'd3
    } state_t;

    localparam int         DEFAULT_TIMEOUT_CYCLES = 64;
    localparam logic [7:0] DEFAULT_FILL_BYTE      = 8'h00;

    // Counter must be able to hold TIMEOUT_CYCLES itself.
    localparam int TIMEOUT_CNT_W = $clog2(DEFAULT_TIMEOUT_CYCLES + 1);

    function automatic int timeout_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs rx bytes into 16-bit words (first byte low); odd tail padded with FILL_BYTE on rx_last.
// Latency: word_pending rises the cycle after the completing byte is accepted.
// Backpressure: rx_ready is low while a completed word waits for word_taken.
//
// Ports: clk/rst; rx_data/rx_valid/rx_last/rx_ready byte stream in;
//        word_taken clears the pending word; word/word_pending hold the completed word.
module byte_word_packer #(
    parameter logic [7:0] FILL_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_last,
    output logic        rx_ready,
    input  logic        word_taken,
    output logic        word_pending,
    output logic [15:0] word
);

    logic [7:0] lo_byte;
    logic       have_lo;
    logic       accept;
    logic       pending_next;

    assign accept = rx_valid && rx_ready;

    // A word completes on the second byte, or on a lone low byte flagged last.
    always_comb begin
        pending_next = word_pending;
        if (word_taken) begin
            pending_next = 1'b0;
        end else if (accept && (have_lo || rx_last)) begin
            pending_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_byte      <= '0;
            have_lo      <= 1'b0;
            word_pending <= 1'b0;
            word         <= '0;
            rx_ready     <= 1'b0;
        end else begin
            word_pending <= pending_next;
            // Registered copy of !word_pending, so accept never races a completion.
            rx_ready     <= !pending_next;
            if (accept) begin
                if (have_lo) begin
                    word    <= {rx_data, lo_byte};
                    have_lo <= 1'b0;
                end else if (rx_last) begin
                    word <= {FILL_BYTE, rx_data};
                end else begin
                    lo_byte <= rx_data;
                    have_lo <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sram_client_port.sv
// Master-side client of the SRAM FIFO controller: rx bytes -> write words, read words -> tx bytes.
// Latency: request rises 1 cycle after its candidate in IDLE; tx_valid rises 1 cycle after a read hint.
// Backpressure: rx stalls while a write word is pending; reads wait until both tx bytes are consumed.
//
// Ports: clk/rst; rx_* byte stream in; tx_* byte stream out; master_write/master_read level
//        requests with master_hint completion pulse and 16-bit data both ways;
//        fifo_o_full/fifo_i_empty gate requests; busy and sticky err_timeout status.
module sram_client_port
    import sram_client_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [7:0] FILL_BYTE      = DEFAULT_FILL_BYTE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_last,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        master_write,
    output logic        master_read,
    output logic [15:0] master_data_to_sram,
    input  logic [15:0] master_data_from_sram,
    input  logic        master_hint,
    input  logic        fifo_o_full,
    input  logic        fifo_i_empty,
    output logic        busy,
    output logic        err_timeout
);

    localparam int               CNT_W    = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_next;
    logic             last_grant_rd;
    logic [CNT_W-1:0] cnt;
    logic             word_pending;
    logic             word_taken;
    logic             rd_load;
    logic             timed_out;
    logic             wr_cand;
    logic             rd_cand;
    logic [7:0]       hi_byte;
    logic             hi_left;

    // The packer's word register stays stable while a write is outstanding,
    // so it drives the write data directly.
    byte_word_packer #(.FILL_BYTE(FILL_BYTE)) u_packer (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_last      (rx_last),
        .rx_ready     (rx_ready),
        .word_taken   (word_taken),
        .word_pending (word_pending),
        .word         (master_data_to_sram)
    );

    assign wr_cand = word_pending && !fifo_o_full;
    // tx_valid is high exactly while the read hold register has unsent bytes.
    assign rd_cand = !tx_valid && !fifo_i_empty;

    always_comb begin
        state_next = state;
        word_taken = 1'b0;
        rd_load    = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                // On contention, grant whichever side did not go last.
                if (wr_cand && (!rd_cand || last_grant_rd)) begin
                    state_next = WR_REQ;
                end else if (rd_cand) begin
                    state_next = RD_REQ;
                end
            end
            WR_REQ: begin
                if (master_hint) begin
                    state_next = COOL;
                    word_taken = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    // Word stays pending and is retried from IDLE.
                    state_next = COOL;
                    timed_out  = 1'b1;
                end
            end
            RD_REQ: begin
                if (master_hint) begin
                    state_next = COOL;
                    rd_load    = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_next = COOL;
                    timed_out  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_grant_rd <= 1'b1;
            cnt           <= '0;
            master_write  <= 1'b0;
            master_read   <= 1'b0;
            busy          <= 1'b0;
            err_timeout   <= 1'b0;
            tx_valid      <= 1'b0;
            tx_data       <= '0;
            hi_byte       <= '0;
            hi_left       <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next == WR_REQ) begin
                last_grant_rd <= 1'b0;
            end
            if (state == IDLE && state_next == RD_REQ) begin
                last_grant_rd <= 1'b1;
            end
            cnt          <= (state == WR_REQ || state == RD_REQ) ? cnt + 1'b1 : '0;
            master_write <= (state_next == WR_REQ);
            master_read  <= (state_next == RD_REQ);
            busy         <= (state_next == WR_REQ) || (state_next == RD_REQ);
            if (timed_out) begin
                err_timeout <= 1'b1;
            end
            if (rd_load) begin
                tx_data  <= master_data_from_sram[7:0];
                hi_byte  <= master_data_from_sram[15:8];
                hi_left  <= 1'b1;
                tx_valid <= 1'b1;
            end else if (tx_valid && tx_ready) begin
                if (hi_left) begin
                    tx_data <= hi_byte;
                    hi_left <= 1'b0;
                end else begin
                    tx_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_client_port.sv
// Bench for sram_client_port with a behavioural SRAM controller and byte/word reference queues.
module tb_sram_client_port;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_last = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        master_write;
    logic        master_read;
    logic [15:0] master_data_to_sram;
    logic [15:0] master_data_from_sram = '0;
    logic        master_hint = 1'b0;
    logic        fifo_o_full = 1'b1;
    logic        fifo_i_empty = 1'b1;
    logic        busy;
    logic        err_timeout;

    always #5 clk = ~clk;

    sram_client_port #(.TIMEOUT_CYCLES(TO), .FILL_BYTE(8'h00)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .rx_data               (rx_data),
        .rx_valid              (rx_valid),
        .rx_last               (rx_last),
        .rx_ready              (rx_ready),
        .tx_data               (tx_data),
        .tx_valid              (tx_valid),
        .tx_ready              (tx_ready),
        .master_write          (master_write),
        .master_read           (master_read),
        .master_data_to_sram   (master_data_to_sram),
        .master_data_from_sram (master_data_from_sram),
        .master_hint           (master_hint),
        .fifo_o_full           (fifo_o_full),
        .fifo_i_empty          (fifo_i_empty),
        .busy                  (busy),
        .err_timeout           (err_timeout)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [8:0]  rx_q[$];
    logic [15:0] exp_wr[$];
    logic [15:0] rd_src[$];
    logic [7:0]  exp_tx[$];
    int          grant_log[$];
    int          formed = 0, written = 0, half = 0;
    bit          exp_err = 1'b0;

    // Knobs
    bit hold_hint = 1'b0, force_full = 1'b0, rd_en = 1'b0, rand_dly = 1'b0;
    int hint_dly = 5, gap_pct = 0, txr_pct = 100, late_cnt = 0;

    // Previous-cycle observations
    bit prev_req = 1'b0, prev_hint = 1'b0, prev_full = 1'b1, prev_iempty = 1'b1, prev_txv = 1'b0;
    int age = 0, prev_age = 0;

    task automatic add_packet(input int n, input logic [55:0] b);
        logic [7:0] hi;
        for (int i = 0; i < n; i++) rx_q.push_back({(i == n - 1), b[8*i +: 8]});
        for (int i = 0; i < n; i += 2) begin
            hi = (i + 1 < n) ? b[8*(i+1) +: 8] : 8'h00;
            exp_wr.push_back({hi, b[8*i +: 8]});
        end
    endtask

    task automatic step();
        bit          mw, mr, req, hint;
        logic [15:0] d;
        @(posedge clk); #1;
        mw  = master_write;
        mr  = master_read;
        req = mw || mr;
        if (prev_req && !req && !prev_hint) begin
            check_eq("to_len", 32'(prev_age + 1), 32'(TO));
            exp_err  = 1'b1;
            late_cnt = 2;
        end
        if (req && !prev_req) begin
            grant_log.push_back(int'(mr));
            if (mw) check_eq("wr_gate", 32'(prev_full), 32'd0);
            else    check_eq("rd_gate", 32'(prev_iempty | prev_txv), 32'd0);
            if (rand_dly) hint_dly = $urandom_range(5, 10);
            age = 0;
        end else if (req) begin
            age++;
        end
        check_eq("excl",   32'(mw & mr), 32'd0);
        check_eq("busy",   32'(busy), 32'(req));
        check_eq("err",    32'(err_timeout), 32'(exp_err));
        check_eq("rx_rdy", 32'(rx_ready), 32'(formed == written));
        check_eq("tx_vld", 32'(tx_valid), 32'(exp_tx.size() != 0));
        if (prev_hint) check_eq("req_drop", 32'(req), 32'd0);

        // Drive this cycle
        hint = 1'b0;
        d    = 16'($urandom);
        if (req && !hold_hint && age >= hint_dly) begin
            hint = 1'b1;
        end else if (!req && late_cnt > 0) begin
            hint = 1'b1;
            late_cnt--;
        end
        if (mr && hint) begin
            if (rd_src.size() == 0) check_eq("rd_underflow", 32'd1, 32'd0);
            else d = rd_src.pop_front();
        end
        master_hint           = hint;
        master_data_from_sram = d;
        fifo_o_full           = force_full;
        fifo_i_empty          = !rd_en || (rd_src.size() == 0);
        if (rx_q.size() != 0 && $urandom_range(0, 99) >= gap_pct) begin
            rx_valid = 1'b1;
            {rx_last, rx_data} = rx_q[0];
        end else begin
            rx_valid = 1'b0;
            rx_last  = 1'($urandom);
            rx_data  = 8'($urandom);
        end
        tx_ready = ($urandom_range(0, 99) < txr_pct);

        // Handshakes completing at the coming edge
        if (rx_valid && rx_ready) begin
            void'(rx_q.pop_front());
            if (half == 1 || rx_last) begin
                formed++;
                half = 0;
            end else begin
                half = 1;
            end
        end
        if (tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) check_eq("tx_extra", 32'd1, 32'd0);
            else check_eq("tx_dat", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
        if (mw && hint) begin
            if (exp_wr.size() == 0) check_eq("wr_extra", 32'd1, 32'd0);
            else check_eq("wr_dat", 32'(master_data_to_sram), 32'(exp_wr.pop_front()));
            written++;
        end
        if (mr && hint) begin
            exp_tx.push_back(d[7:0]);
            exp_tx.push_back(d[15:8]);
        end
        prev_req    = req;
        prev_hint   = hint && req;
        prev_full   = fifo_o_full;
        prev_iempty = fifo_i_empty;
        prev_txv    = tx_valid;
        prev_age    = age;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        master_hint  = 1'b0;
        rx_valid     = 1'b0;
        tx_ready     = 1'b0;
        fifo_o_full  = 1'b1;
        fifo_i_empty = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_mw",   32'(master_write), 32'd0);
        check_eq("rst_mr",   32'(master_read), 32'd0);
        check_eq("rst_wdat", 32'(master_data_to_sram), 32'd0);
        check_eq("rst_txv",  32'(tx_valid), 32'd0);
        check_eq("rst_txd",  32'(tx_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_err",  32'(err_timeout), 32'd0);
        check_eq("rst_rxr",  32'(rx_ready), 32'd0);
        rx_q.delete();
        exp_wr.delete();
        exp_tx.delete();
        formed = 0; written = 0; half = 0;
        exp_err = 1'b0; late_cnt = 0; age = 0; prev_age = 0;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rxr_after_rst", 32'(rx_ready), 32'd1);
        prev_req = 1'b0; prev_hint = 1'b0; prev_full = 1'b1; prev_iempty = 1'b1; prev_txv = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((rx_q.size() != 0 || exp_wr.size() != 0 || exp_tx.size() != 0 ||
                (rd_en && rd_src.size() != 0) || busy) && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, 32'(n < budget), 32'd1);
    endtask

    initial begin
        int n;
        logic [63:0] r;
        do_reset();

        // Two bytes -> one write of 16'h2211
        add_packet(2, 56'h2211);
        wait_idle("t_pair", 200);

        // Odd packet: B2A1 then padded 00C3
        add_packet(3, 56'hC3B2A1);
        wait_idle("t_odd", 200);

        // Read BEEF -> EF, BE
        rd_en = 1'b1;
        rd_src.push_back(16'hBEEF);
        wait_idle("t_read", 200);

        // Contention: write and read become candidates in the same cycle
        force_full = 1'b1;
        rd_en = 1'b0;
        add_packet(4, 56'h44332211);
        for (int i = 0; i < 10; i++) step();
        grant_log.delete();
        rd_src.push_back(16'h5AA5);
        rd_src.push_back(16'hC33C);
        force_full = 1'b0;
        rd_en = 1'b1;
        wait_idle("t_arb", 400);
        check_eq("arb_cnt", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() >= 4) begin
            check_eq("arb0", 32'(grant_log[0]), 32'd0);
            check_eq("arb1", 32'(grant_log[1]), 32'd1);
            check_eq("arb2", 32'(grant_log[2]), 32'd0);
            check_eq("arb3", 32'(grant_log[3]), 32'd1);
        end

        // Output FIFO full: reads proceed, write held back
        force_full = 1'b1;
        add_packet(2, 56'h7788);
        rd_src.push_back(16'h0102);
        rd_src.push_back(16'h0304);
        n = 0;
        while ((rd_src.size() != 0 || exp_tx.size() != 0 || busy || rx_q.size() != 0) && n < 400) begin
            step();
            n++;
        end
        check_eq("full_wait", 32'(n < 400), 32'd1);
        check_eq("full_hold", 32'(exp_wr.size()), 32'd1);
        force_full = 1'b0;
        wait_idle("t_full_rel", 200);

        // Timeout on write, late hints in COOL/IDLE, then retry
        hold_hint = 1'b1;
        add_packet(2, 56'hABCD);
        n = 0;
        while (!exp_err && n < 300) begin
            step();
            n++;
        end
        check_eq("to_seen", 32'(exp_err), 32'd1);
        hold_hint = 1'b0;
        wait_idle("t_retry", 300);
        check_eq("err_sticky", 32'(err_timeout), 32'd1);

        // Reset while in RD_REQ
        hold_hint = 1'b1;
        rd_src.push_back(16'h1234);
        n = 0;
        while (!master_read && n < 100) begin
            step();
            n++;
        end
        check_eq("rd_req_seen", 32'(master_read), 32'd1);
        do_reset();
        hold_hint = 1'b0;
        wait_idle("t_after_rst", 300);

        // Randomized traffic
        rand_dly = 1'b1;
        gap_pct  = 30;
        txr_pct  = 60;
        for (int c = 0; c < 1500; c++) begin
            if (rx_q.size() < 20 && $urandom_range(0, 99) < 5) begin
                r = {$urandom(), $urandom()};
                add_packet($urandom_range(1, 7), r[55:0]);
            end
            if (rd_src.size() < 8 && $urandom_range(0, 99) < 4) rd_src.push_back(16'($urandom));
            if ($urandom_range(0, 99) < 5) force_full = !force_full;
            step();
        end
        force_full = 1'b0;
        wait_idle("t_drain", 4000);
        check_eq("end_q", 32'(rx_q.size() + exp_wr.size() + exp_tx.size() + rd_src.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_client_port.md
# sram_client_port

Requester-side adapter for the master port of the SRAM FIFO controller. Packs received radio bytes into 16-bit words and pushes them into the output FIFO (`master_write`/`master_hint`). Pops 16-bit words from the input FIFO (`master_read`/`master_hint`) and streams them out as bytes to the radio transmitter. It is the other end of the level-request / one-cycle-hint handshake and sits between the wireless control logic and the SRAM controller.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: cycles from request assertion to abort if no hint arrives.
- `FILL_BYTE`, 8'h00: pad value for the high byte of an odd-length tail word.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in 8: byte from the radio receiver.
- `rx_valid` in 1: `rx_data` valid.
- `rx_last` in 1: marks the final byte of a packet; qualified by `rx_valid`.
- `rx_ready` out 1: byte accepted when `rx_valid && rx_ready`.
- `tx_data` out 8: byte to the radio transmitter.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: byte consumed when `tx_valid && tx_ready`.
- `master_write` out 1: write request to the SRAM controller (level).
- `master_read` out 1: read request to the SRAM controller (level).
- `master_data_to_sram` out 16: write word, held stable while `master_write` is high.
- `master_data_from_sram` in 16: read word, valid in the `master_hint` cycle.
- `master_hint` in 1: one-cycle completion pulse.
- `fifo_o_full` in 1: output FIFO full.
- `fifo_i_empty` in 1: input FIFO empty.
- `busy` out 1: a request is outstanding.
- `err_timeout` out 1: sticky; set on timeout abort, cleared only by `rst`.

## Operation
- Pack path:
  - First accepted byte goes to `[7:0]`, second to `[15:8]`; a word is then pending.
  - A byte with `rx_last` while `[7:0]` only is held: the word completes with `[15:8]=FILL_BYTE`.
  - `rx_ready` = !word_pending.
- Unpack path:
  - Hold register `rd_word` plus byte select.
  - `[7:0]` is sent first, then `[15:8]`.
  - `tx_valid` stays high while `rd_word` holds unsent bytes.
- FSM states:
  - IDLE:
    - The write candidate is word_pending && !fifo_o_full.
    - The read candidate is rd_word empty && !fifo_i_empty.
    - If both are candidates, alternate using a last_grant bit (reset value: last=read, so write goes first).
    - Go to WR_REQ or RD_REQ.
  - WR_REQ:
    - Hold `master_write`=1.
    - On `master_hint`, clear word_pending and go to COOL.
  - RD_REQ:
    - Hold `master_read`=1.
    - On `master_hint`, load `rd_word` from `master_data_from_sram`, set byte select=0, go to COOL.
  - COOL: one cycle with both requests low, then IDLE.
- Request rules:
  - `master_read` and `master_write` are never high together.
  - A request is never raised while the matching full/empty flag blocks it. The controller's priority chain stalls lower requests behind a blocked one.
- Timeout:
  - A counter runs in WR_REQ/RD_REQ.
  - On reaching `TIMEOUT_CYCLES`: drop the request, set `err_timeout`, go to COOL.
  - A pending write word is retained and retried.
- `master_hint` seen in IDLE or COOL is ignored, including a late hint after a timeout; the data is discarded.
- `rst`:
  - Aborts immediately: requests go low at the next edge.
  - Partial and pending words are discarded and `rd_word` is emptied.

## Timing
- Reset values:
  - `master_write`=0, `master_read`=0, `master_data_to_sram`=0.
  - `tx_valid`=0, `tx_data`=0, `busy`=0, `err_timeout`=0.
  - `rx_ready`=0 during `rst`, 1 the first cycle after.
- All outputs are registered.
- Request is asserted 1 cycle after its candidate condition in IDLE.
- The controller returns `master_hint` at least 5 cycles after it samples the request.
- Request deasserts the cycle after the hint. The controller re-arbitrates 2 cycles after its hint, so it never sees a stale request.
- Read: `tx_valid` rises the cycle after the hint.
- Minimum per-word turnaround is 8 cycles (request, ≥5 controller cycles, hint, COOL).
- `busy` is high exactly while in WR_REQ or RD_REQ.

## Structure
- Package `sram_client_pkg` holds:
  - the state enum (IDLE, WR_REQ, RD_REQ, COOL);
  - default `TIMEOUT_CYCLES` and `FILL_BYTE`;
  - the timeout counter width as `$clog2(TIMEOUT_CYCLES+1)`.
- One natural sub-module: `byte_word_packer`, which is the rx-side byte-to-word packer with the `rx_last` pad.

## Test plan
- Bytes 0x11, 0x22 on rx -> one `master_write` with `master_data_to_sram`=16'h2211; request drops the cycle after the hint; `rx_ready` is low meanwhile.
- Three bytes 0xA1, 0xB2, 0xC3 with `rx_last` on 0xC3 -> writes 16'hB2A1 then 16'h00C3.
- `fifo_i_empty`=0, hint data 16'hBEEF, `tx_ready`=1 -> `tx_data` 0xEF then 0xBE on consecutive cycles; the next `master_read` follows only after both bytes are sent.
- Write pending and read possible at the same time -> write granted first, then read, alternating; `master_read` and `master_write` are never both high; with `fifo_o_full`=1 no `master_write` is issued while reads still proceed.
- Hint withheld -> request drops after 64 cycles, `err_timeout`=1, the write word is retried, and a late hint in COOL/IDLE is ignored.
- `rst` asserted while in RD_REQ -> `master_read`=0 the next cycle, `tx_valid`=0, `err_timeout`=0.
